// File: rtl/periph_regbus_bridge.sv
// periph_regbus_bridge
// OBI slave to register-bus bridge. Accepts one OBI transaction at a time,
// decodes the address against NPORTS base/mask rules (lowest matching index
// wins), drives exactly one register-bus port and returns the response on the
// OBI R channel. Decode misses and access timeouts return ERR_DATA with the
// error flag set, raise a sticky interrupt and capture the first fault address.
//
// Ports
//   clk_i, rst_ni        clock, synchronous active-low reset
//   req_i/gnt_o          OBI request/grant (grant is combinational in IDLE)
//   addr_i/we_i/be_i/wdata_i   OBI request payload
//   rvalid_o/rdata_o/err_o     OBI response (data/err zero when not valid)
//   reg_valid_o          one-hot register-bus valid, one bit per port
//   reg_addr_o/reg_write_o/reg_wdata_o/reg_wstrb_o  shared latched request
//   reg_ready_i/reg_rdata_i/reg_error_i             per-port slave response
//   err_irq_o/err_addr_o sticky bus-fault interrupt and first fault address
//   err_clr_i            clears err_irq_o and err_addr_o
module periph_regbus_bridge #(
   parameter int unsigned          NPORTS    = 4,
   parameter int unsigned          AW        = 32,
   parameter int unsigned          DW        = 32,
   parameter logic [NPORTS*AW-1:0] RULE_BASE = '0,
   parameter logic [NPORTS*AW-1:0] RULE_MASK = '0,
   parameter int unsigned          TIMEOUT   = 255,
   parameter logic [DW-1:0]        ERR_DATA  = DW'(32'hBADC_AB1E)
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 req_i,
   output logic                 gnt_o,
   input  logic [AW-1:0]        addr_i,
   input  logic                 we_i,
   input  logic [DW/8-1:0]      be_i,
   input  logic [DW-1:0]        wdata_i,
   output logic                 rvalid_o,
   output logic [DW-1:0]        rdata_o,
   output logic                 err_o,
   output logic [NPORTS-1:0]    reg_valid_o,
   output logic [AW-1:0]        reg_addr_o,
   output logic                 reg_write_o,
   output logic [DW-1:0]        reg_wdata_o,
   output logic [DW/8-1:0]      reg_wstrb_o,
   input  logic [NPORTS-1:0]    reg_ready_i,
   input  logic [NPORTS*DW-1:0] reg_rdata_i,
   input  logic [NPORTS-1:0]    reg_error_i,
   output logic                 err_irq_o,
   output logic [AW-1:0]        err_addr_o,
   input  logic                 err_clr_i
);

   localparam int unsigned SW = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   // Wide enough to hold TIMEOUT-1; with TIMEOUT=0 the counter just wraps unused.
   localparam int unsigned CW = $clog2(TIMEOUT + 2);
   localparam logic [CW-1:0] CNT_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic            we_q, we_d;
   logic [DW/8-1:0] be_q, be_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [SW-1:0]   sel_q, sel_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic            err_q, err_d;
   logic            irq_q, irq_d;
   logic [AW-1:0]   eaddr_q, eaddr_d;

   logic            dec_hit_s;
   logic [SW-1:0]   dec_sel_s;
   logic            rdy_sel_s;
   logic            err_sel_s;
   logic [DW-1:0]   rd_sel_s;
   logic            fault_s;
   logic [AW-1:0]   fault_addr_s;
   logic            gnt_s;

   // Address decode: scan from the top so the lowest matching index is the last write.
   always_comb begin
      dec_hit_s = 1'b0;
      dec_sel_s = '0;
      for (int i = int'(NPORTS) - 1; i >= 0; i--) begin
         if ((addr_i & RULE_MASK[i*AW +: AW]) == (RULE_BASE[i*AW +: AW] & RULE_MASK[i*AW +: AW])) begin
            dec_hit_s = 1'b1;
            dec_sel_s = SW'(i);
         end else begin
            dec_hit_s = dec_hit_s;
         end
      end
   end

   // Select the response signals of the currently addressed port.
   always_comb begin
      rdy_sel_s = 1'b0;
      err_sel_s = 1'b0;
      rd_sel_s  = '0;
      for (int i = 0; i < int'(NPORTS); i++) begin
         if (SW'(i) == sel_q) begin
            rdy_sel_s = reg_ready_i[i];
            err_sel_s = reg_error_i[i];
            rd_sel_s  = reg_rdata_i[i*DW +: DW];
         end else begin
            rdy_sel_s = rdy_sel_s;
         end
      end
   end

   // Next-state, request latching, response capture and fault/IRQ tracking.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      we_d         = we_q;
      be_d         = be_q;
      wdata_d      = wdata_q;
      sel_d        = sel_q;
      cnt_d        = cnt_q;
      rdata_d      = rdata_q;
      err_d        = err_q;
      irq_d        = irq_q;
      eaddr_d      = eaddr_q;
      fault_s      = 1'b0;
      fault_addr_s = addr_q;
      gnt_s        = 1'b0;

      case (state_q)
         IDLE: begin
            gnt_s = req_i;
            if (req_i) begin
               addr_d  = addr_i;
               we_d    = we_i;
               be_d    = be_i;
               wdata_d = wdata_i;
               sel_d   = dec_sel_s;
               cnt_d   = '0;
               if (dec_hit_s) begin
                  state_d = ACCESS;
               end else begin
                  // Miss: respond directly, the register bus never sees it.
                  state_d      = RESP;
                  rdata_d      = ERR_DATA;
                  err_d        = 1'b1;
                  fault_s      = 1'b1;
                  fault_addr_s = addr_i;
               end
            end else begin
               state_d = IDLE;
            end
         end
         ACCESS: begin
            // Ready is checked first so a ready on the last allowed cycle wins.
            if (rdy_sel_s) begin
               state_d = RESP;
               rdata_d = we_q ? '0 : rd_sel_s;
               err_d   = err_sel_s;
            end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
               state_d = RESP;
               rdata_d = ERR_DATA;
               err_d   = 1'b1;
               fault_s = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1'b1);
            end
         end
         RESP: begin
            state_d = IDLE;
            rdata_d = '0;
            err_d   = 1'b0;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // A new fault beats a simultaneous clear; otherwise the first fault is kept.
      if (fault_s) begin
         irq_d = 1'b1;
         if (!irq_q || err_clr_i) begin
            eaddr_d = fault_addr_s;
         end else begin
            eaddr_d = eaddr_q;
         end
      end else if (err_clr_i) begin
         irq_d   = 1'b0;
         eaddr_d = '0;
      end else begin
         irq_d = irq_q;
      end
   end

   // State and datapath registers with synchronous active-low reset.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         addr_q  <= '0;
         we_q    <= 1'b0;
         be_q    <= '0;
         wdata_q <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
         irq_q   <= 1'b0;
         eaddr_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         irq_q   <= irq_d;
         eaddr_q <= eaddr_d;
      end
   end

   assign gnt_o       = gnt_s;
   assign rvalid_o    = (state_q == RESP);
   assign rdata_o     = (state_q == RESP) ? rdata_q : '0;
   assign err_o       = (state_q == RESP) ? err_q : 1'b0;
   assign reg_valid_o = (state_q == ACCESS) ? (NPORTS'(1'b1) << sel_q) : '0;
   assign reg_addr_o  = addr_q;
   assign reg_write_o = we_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = be_q;
   assign err_irq_o   = irq_q;
   assign err_addr_o  = eaddr_q;

endmodule

// File: tb/tb_periph_regbus_bridge.sv
// Directed testbench for periph_regbus_bridge with NPORTS=4, TIMEOUT=8.
// Rules: port0 0x3xxx, port1 0x30xx (overlaps port0), port2 0x2xxx, port3 0x4xxx.
module tb_periph_regbus_bridge;

   localparam int unsigned NP = 4;
   localparam logic [NP*32-1:0] BASES = {32'h0000_4000, 32'h0000_2000, 32'h0000_3000, 32'h0000_3000};
   localparam logic [NP*32-1:0] MASKS = {32'h0000_F000, 32'h0000_F000, 32'h0000_FF00, 32'h0000_F000};

   logic          clk_i = 1'b0;
   logic          rst_ni;
   logic          req_i;
   logic          gnt_o;
   logic [31:0]   addr_i;
   logic          we_i;
   logic [3:0]    be_i;
   logic [31:0]   wdata_i;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          err_o;
   logic [NP-1:0] reg_valid_o;
   logic [31:0]   reg_addr_o;
   logic          reg_write_o;
   logic [31:0]   reg_wdata_o;
   logic [3:0]    reg_wstrb_o;
   logic [NP-1:0] reg_ready_i;
   logic [NP*32-1:0] reg_rdata_i;
   logic [NP-1:0] reg_error_i;
   logic          err_irq_o;
   logic [31:0]   err_addr_o;
   logic          err_clr_i;

   int n_cmp = 0;
   int n_mis = 0;

   periph_regbus_bridge #(
      .NPORTS(NP), .AW(32), .DW(32), .RULE_BASE(BASES), .RULE_MASK(MASKS),
      .TIMEOUT(8), .ERR_DATA(32'hBADC_AB1E)
   ) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .gnt_o(gnt_o),
      .addr_i(addr_i), .we_i(we_i), .be_i(be_i), .wdata_i(wdata_i),
      .rvalid_o(rvalid_o), .rdata_o(rdata_o), .err_o(err_o),
      .reg_valid_o(reg_valid_o), .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o),
      .reg_wdata_o(reg_wdata_o), .reg_wstrb_o(reg_wstrb_o), .reg_ready_i(reg_ready_i),
      .reg_rdata_i(reg_rdata_i), .reg_error_i(reg_error_i), .err_irq_o(err_irq_o),
      .err_addr_o(err_addr_o), .err_clr_i(err_clr_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Present a request right after an edge and check the combinational grant.
   task automatic issue(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
      req_i = 1'b1; addr_i = a; we_i = w; be_i = b; wdata_i = d;
      #1;
      chk("gnt_idle", gnt_o, 1'b1);
   endtask

   task automatic chk_resp(input string tag, input logic [31:0] rd, input logic er);
      chk({tag, "_rvalid"}, rvalid_o, 1'b1);
      chk({tag, "_rdata"}, rdata_o, rd);
      chk({tag, "_err"}, err_o, er);
      chk({tag, "_regvalid"}, reg_valid_o, 4'b0000);
   endtask

   initial begin
      rst_ni = 1'b0; req_i = 1'b0; addr_i = 32'h0; we_i = 1'b0; be_i = 4'h0;
      wdata_i = 32'h0; reg_ready_i = 4'b0000; reg_rdata_i = '0; reg_error_i = 4'b0000;
      err_clr_i = 1'b0;
      repeat (3) cyc();
      // Reset state
      chk("rst_gnt", gnt_o, 1'b0);
      chk("rst_rvalid", rvalid_o, 1'b0);
      chk("rst_rdata", rdata_o, 32'h0);
      chk("rst_regvalid", reg_valid_o, 4'b0000);
      chk("rst_irq", err_irq_o, 1'b0);
      chk("rst_eaddr", err_addr_o, 32'h0);
      chk("rst_regaddr", reg_addr_o, 32'h0);
      rst_ni = 1'b1;
      cyc();

      // Read hit on port 2, zero-wait slave
      issue(32'h0000_2004, 1'b0, 4'hF, 32'h0);
      reg_ready_i = 4'b0100; reg_rdata_i[2*32 +: 32] = 32'h1234_5678;
      cyc();
      chk("rd_gnt_access", gnt_o, 1'b0);
      chk("rd_regvalid", reg_valid_o, 4'b0100);
      chk("rd_regaddr", reg_addr_o, 32'h0000_2004);
      chk("rd_rvalid_c1", rvalid_o, 1'b0);
      req_i = 1'b0;
      cyc();
      chk_resp("rd", 32'h1234_5678, 1'b0);
      reg_ready_i = 4'b0000;
      cyc();
      chk("rd_rvalid_c3", rvalid_o, 1'b0);
      chk("rd_rdata_c3", rdata_o, 32'h0);

      // Write, slave ready on 5th access cycle
      issue(32'h0000_2008, 1'b1, 4'h3, 32'h0000_AABB);
      for (int k = 1; k <= 5; k++) begin
         cyc();
         req_i = 1'b0;
         if (k == 5) reg_ready_i = 4'b0100;
         #1;
         chk("wr_regvalid", reg_valid_o, 4'b0100);
         chk("wr_wstrb", reg_wstrb_o, 4'h3);
         chk("wr_rvalid_low", rvalid_o, 1'b0);
      end
      chk("wr_write", reg_write_o, 1'b1);
      chk("wr_wdata", reg_wdata_o, 32'h0000_AABB);
      cyc();
      chk_resp("wr", 32'h0, 1'b0);
      reg_ready_i = 4'b0000;
      cyc();

      // Decode miss
      issue(32'h0000_F000, 1'b0, 4'hF, 32'h0);
      cyc();
      req_i = 1'b0;
      chk_resp("miss", 32'hBADC_AB1E, 1'b1);
      chk("miss_irq", err_irq_o, 1'b1);
      chk("miss_eaddr", err_addr_o, 32'h0000_F000);
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      chk("clr_irq", err_irq_o, 1'b0);
      chk("clr_eaddr", err_addr_o, 32'h0);

      // First timeout at 0x2000
      issue(32'h0000_2000, 1'b0, 4'hF, 32'h0);
      for (int k = 1; k <= 8; k++) begin
         cyc();
         req_i = 1'b0;
         chk("to1_regvalid", reg_valid_o, 4'b0100);
         chk("to1_rvalid_low", rvalid_o, 1'b0);
      end
      cyc();
      chk_resp("to1", 32'hBADC_AB1E, 1'b1);
      chk("to1_irq", err_irq_o, 1'b1);
      chk("to1_eaddr", err_addr_o, 32'h0000_2000);
      cyc();

      // Second timeout keeps the first fault address
      issue(32'h0000_2010, 1'b0, 4'hF, 32'h0);
      repeat (9) begin
         cyc();
         req_i = 1'b0;
      end
      chk_resp("to2", 32'hBADC_AB1E, 1'b1);
      chk("to2_eaddr", err_addr_o, 32'h0000_2000);
      cyc();

      // Clear coinciding with a new miss: new fault wins
      err_clr_i = 1'b1;
      issue(32'h0000_F004, 1'b0, 4'hF, 32'h0);
      cyc();
      req_i = 1'b0; err_clr_i = 1'b0;
      chk("clrmiss_irq", err_irq_o, 1'b1);
      chk("clrmiss_eaddr", err_addr_o, 32'h0000_F004);
      err_clr_i = 1'b1;
      cyc();
      err_clr_i = 1'b0;
      chk("clr2_irq", err_irq_o, 1'b0);

      // Ready on the 8th (last) access cycle wins over timeout
      issue(32'h0000_2004, 1'b0, 4'hF, 32'h0);
      reg_rdata_i[2*32 +: 32] = 32'hCAFE_F00D;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         req_i = 1'b0;
         if (k == 8) reg_ready_i = 4'b0100;
      end
      cyc();
      chk_resp("last", 32'hCAFE_F00D, 1'b0);
      chk("last_irq", err_irq_o, 1'b0);
      reg_ready_i = 4'b0000;
      cyc();

      // Slave error on port 3: err_o only, no IRQ
      issue(32'h0000_4000, 1'b0, 4'hF, 32'h0);
      reg_ready_i = 4'b1000; reg_error_i = 4'b1000; reg_rdata_i[3*32 +: 32] = 32'h0000_5A5A;
      cyc();
      req_i = 1'b0;
      chk("serr_regvalid", reg_valid_o, 4'b1000);
      cyc();
      chk_resp("serr", 32'h0000_5A5A, 1'b1);
      chk("serr_irq", err_irq_o, 1'b0);
      reg_ready_i = 4'b0000; reg_error_i = 4'b0000;
      cyc();

      // Overlapping rules: port 0 wins over port 1
      issue(32'h0000_3004, 1'b0, 4'hF, 32'h0);
      reg_ready_i = 4'b0011;
      reg_rdata_i[0*32 +: 32] = 32'h0000_0A0A; reg_rdata_i[1*32 +: 32] = 32'h0000_0B0B;
      cyc();
      req_i = 1'b0;
      chk("ovl_regvalid", reg_valid_o, 4'b0001);
      cyc();
      chk_resp("ovl", 32'h0000_0A0A, 1'b0);
      reg_ready_i = 4'b0000;
      cyc();

      // Reset during ACCESS drops the transaction
      issue(32'h0000_2000, 1'b0, 4'hF, 32'h0);
      cyc();
      req_i = 1'b0;
      chk("rstacc_regvalid", reg_valid_o, 4'b0100);
      rst_ni = 1'b0;
      cyc();
      chk("rstacc_regvalid0", reg_valid_o, 4'b0000);
      chk("rstacc_rvalid", rvalid_o, 1'b0);
      chk("rstacc_regaddr", reg_addr_o, 32'h0);
      rst_ni = 1'b1;
      cyc();
      chk("rstacc_rvalid2", rvalid_o, 1'b0);
      issue(32'h0000_4008, 1'b0, 4'hF, 32'h0);
      reg_ready_i = 4'b1000; reg_rdata_i[3*32 +: 32] = 32'h0000_7777;
      cyc();
      req_i = 1'b0;
      chk("post_regvalid", reg_valid_o, 4'b1000);
      cyc();
      chk_resp("post", 32'h0000_7777, 1'b0);
      reg_ready_i = 4'b0000;
      cyc();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
